// File: rtl/memory_handler_pkg.sv
// Shared types and constants for the memory_handler data-memory access stage.
// Optional build macro: MEM_MISALIGN_CHECK_EN (rejects unaligned lw/sw).
package memory_handler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] SEL_WORD  = 4'hF;
  localparam logic [3:0] SEL_BYTE0 = 4'b0001;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/memory_handler_byte_lane_unit.sv
// Combinational byte-lane logic: store lane enables/replication and lb
// lane extraction with sign extension.
module byte_lane_unit
  import memory_handler_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic        byte_op,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0] lane;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    lane = rdata[7:0];
    unique case (addr_lo)
      2'd0: lane = rdata[7:0];
      2'd1: lane = rdata[15:8];
      2'd2: lane = rdata[23:16];
      2'd3: lane = rdata[31:24];
    endcase

    sel       = byte_op ? (SEL_BYTE0 << addr_lo) : SEL_WORD;
    bus_wdata = byte_op ? {4{wdata[7:0]}} : wdata;
    rdata_ext = byte_op ? sext8(lane) : rdata;
  end

endmodule

// File: rtl/memory_handler.sv
// Data-memory access stage: one outstanding bus transaction, pipeline freeze,
// timeout abort. Optional build macro: MEM_MISALIGN_CHECK_EN.
module memory_handler
  import memory_handler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        freeze,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               load_byte_q, load_byte_d;
  logic               store_byte_q, store_byte_d;
  logic               is_read_q, is_read_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_valid_q, load_valid_d;
  logic               mem_err_q, mem_err_d;

  logic        req_one, req_both, misaligned, timeout_hit, active;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, rdata_ext;

  assign req_one     = read_mem ^ write_mem;
  assign req_both    = read_mem & write_mem;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (read_mem ? ~load_byte : ~store_byte) & (addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  byte_lane_unit u_lanes (
    .addr_lo   (addr_q[1:0]),
    .byte_op   (is_read_q ? load_byte_q : store_byte_q),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .sel       (lane_sel),
    .bus_wdata (lane_wdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_byte_q  <= 1'b0;
      store_byte_q <= 1'b0;
      is_read_q    <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      load_byte_q  <= load_byte_d;
      store_byte_q <= store_byte_d;
      is_read_q    <= is_read_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      mem_err_q    <= mem_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_byte_d  = load_byte_q;
    store_byte_d = store_byte_q;
    is_read_d    = is_read_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    mem_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_both) begin
          mem_err_d = 1'b1;
        end else if (req_one) begin
          addr_d       = addr;
          wdata_d      = wdata;
          load_byte_d  = load_byte;
          store_byte_d = store_byte;
          is_read_d    = read_mem;
          if (misaligned) begin
            state_d   = DONE;
            mem_err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (!bus_busy) begin
          state_d = DONE;
          if (is_read_q) begin
            load_data_d  = rdata_ext;
            load_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d     = DONE;
          mem_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Bus fields are zero outside REQ/WAIT so reset leaves every output at 0.
  always_comb begin
    active     = (state_q == REQ) || (state_q == WAIT);
    bus_read   = (state_q == REQ) && is_read_q;
    bus_write  = (state_q == REQ) && !is_read_q;
    bus_addr   = active ? {addr_q[31:2], 2'b00} : 32'h0;
    bus_sel    = active ? lane_sel : 4'h0;
    bus_wdata  = active ? lane_wdata : 32'h0;
    freeze     = active || ((state_q == IDLE) && req_one && nrst);
    load_data  = load_data_q;
    load_valid = load_valid_q;
    mem_err    = mem_err_q;
  end

endmodule

// File: tb/tb_memory_handler.sv
// Directed self-checking bench for memory_handler: store/load timing, lanes,
// timeout, async reset, illegal and misaligned requests.
module tb_memory_handler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read_mem, write_mem, load_byte, store_byte;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_busy;
  logic        bus_read, bus_write, freeze, load_valid, mem_err;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_sel;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_handler #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .addr       (addr),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .bus_busy   (bus_busy),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_sel    (bus_sel),
    .freeze     (freeze),
    .load_data  (load_data),
    .load_valid (load_valid),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; read_mem = 0; write_mem = 0; load_byte = 0; store_byte = 0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_busy = 0;
    #3;
    tests_run++;
    if ({bus_read, bus_write, freeze, load_valid, mem_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b exp 00000", {bus_read, bus_write, freeze, load_valid, mem_err});
    end
    tests_run++;
    if ({bus_addr, bus_wdata, load_data, bus_sel} !== 100'b0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h wdata %h ld %h sel %h exp all 0", bus_addr, bus_wdata, load_data, bus_sel);
    end
    next_cycle();
    next_cycle();
    nrst = 1'b1;
    next_cycle();
  endtask

  task automatic test_sw();
    write_mem = 1; store_byte = 0; addr = 32'h100; wdata = 32'hDEADBEEF; bus_busy = 0;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus_write !== (c == 1)) begin
        tests_failed++; $display("FAIL sw_write c%0d: got %b exp %b", c, bus_write, c == 1);
      end
      tests_run++;
      if (freeze !== (c <= 2)) begin
        tests_failed++; $display("FAIL sw_freeze c%0d: got %b exp %b", c, freeze, c <= 2);
      end
      tests_run++;
      if (load_valid !== 1'b0 || bus_read !== 1'b0) begin
        tests_failed++; $display("FAIL sw_noload c%0d: valid %b read %b exp 0 0", c, load_valid, bus_read);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_addr !== 32'h100 || bus_sel !== 4'hF || bus_wdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("FAIL sw_bus: addr %h sel %h wdata %h exp 00000100 f deadbeef", bus_addr, bus_sel, bus_wdata);
        end
      end
      next_cycle();
      if (c == 0) write_mem = 0;
    end
  endtask

  task automatic test_sb();
    write_mem = 1; store_byte = 1; addr = 32'h203; wdata = 32'h000000A5; bus_busy = 0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        tests_run++;
        if (bus_addr !== 32'h200 || bus_sel !== 4'b1000 || bus_wdata !== 32'hA5A5A5A5) begin
          tests_failed++;
          $display("FAIL sb_bus c%0d: addr %h sel %b wdata %h exp 00000200 1000 a5a5a5a5", c, bus_addr, bus_sel, bus_wdata);
        end
      end
      tests_run++;
      if (bus_write !== (c == 1)) begin
        tests_failed++; $display("FAIL sb_write c%0d: got %b exp %b", c, bus_write, c == 1);
      end
      next_cycle();
      if (c == 0) begin write_mem = 0; store_byte = 0; end
    end
  endtask

  task automatic test_lb_busy();
    read_mem = 1; load_byte = 1; addr = 32'h302; bus_rdata = 32'h12F45678; bus_busy = 1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus_read !== (c == 1)) begin
        tests_failed++; $display("FAIL lb_read c%0d: got %b exp %b", c, bus_read, c == 1);
      end
      tests_run++;
      if (freeze !== (c <= 5)) begin
        tests_failed++; $display("FAIL lb_freeze c%0d: got %b exp %b", c, freeze, c <= 5);
      end
      tests_run++;
      if (load_valid !== (c == 6)) begin
        tests_failed++; $display("FAIL lb_valid c%0d: got %b exp %b", c, load_valid, c == 6);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_sel !== 4'b0100 || bus_addr !== 32'h300) begin
          tests_failed++; $display("FAIL lb_bus: sel %b addr %h exp 0100 00000300", bus_sel, bus_addr);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (load_data !== 32'hFFFFFFF4) begin
          tests_failed++; $display("FAIL lb_data: got %h exp fffffff4", load_data);
        end
      end
      next_cycle();
      if (c == 0) begin read_mem = 0; load_byte = 0; end
      if (c == 4) bus_busy = 0;
    end
  endtask

  task automatic test_timeout();
    read_mem = 1; load_byte = 0; addr = 32'h400; bus_rdata = 32'h55AA55AA; bus_busy = 1;
    for (int c = 0; c <= 67; c++) begin
      @(negedge clk);
      tests_run++;
      if (freeze !== (c <= 65)) begin
        tests_failed++; $display("FAIL to_freeze c%0d: got %b exp %b", c, freeze, c <= 65);
      end
      tests_run++;
      if (mem_err !== (c == 66)) begin
        tests_failed++; $display("FAIL to_err c%0d: got %b exp %b", c, mem_err, c == 66);
      end
      tests_run++;
      if (bus_read !== (c == 1) || load_valid !== 1'b0) begin
        tests_failed++; $display("FAIL to_strobe c%0d: read %b valid %b exp %b 0", c, bus_read, load_valid, c == 1);
      end
      if (c == 66) begin
        tests_run++;
        if (load_data !== 32'h0) begin
          tests_failed++; $display("FAIL to_data: got %h exp 00000000", load_data);
        end
      end
      next_cycle();
      if (c == 0) read_mem = 0;
    end
    bus_busy = 0;
  endtask

  task automatic test_reset_mid();
    read_mem = 1; load_byte = 0; addr = 32'h500; bus_rdata = 32'h0; bus_busy = 1;
    next_cycle();
    read_mem = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (freeze !== 1'b1) begin
      tests_failed++; $display("FAIL rst_pre_freeze: got %b exp 1", freeze);
    end
    #1 nrst = 1'b0;
    #1;
    tests_run++;
    if (freeze !== 1'b0 || bus_read !== 1'b0 || bus_addr !== 32'h0 || bus_sel !== 4'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: freeze %b read %b addr %h sel %h exp 0 0 0 0", freeze, bus_read, bus_addr, bus_sel);
    end
    next_cycle();
    nrst = 1'b1; bus_busy = 0;
    read_mem = 1; addr = 32'h504; bus_rdata = 32'hCAFEF00D;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (freeze !== (c <= 2) || bus_read !== (c == 1) || load_valid !== (c == 3)) begin
        tests_failed++;
        $display("FAIL rst_after c%0d: freeze %b read %b valid %b", c, freeze, bus_read, load_valid);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_addr !== 32'h504) begin
          tests_failed++; $display("FAIL rst_after_addr: got %h exp 00000504", bus_addr);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (load_data !== 32'hCAFEF00D) begin
          tests_failed++; $display("FAIL rst_after_data: got %h exp cafef00d", load_data);
        end
      end
      next_cycle();
      if (c == 0) read_mem = 0;
    end
  endtask

  task automatic test_illegal();
    read_mem = 1; write_mem = 1; addr = 32'h600;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (freeze !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0) begin
        tests_failed++;
        $display("FAIL ill_bus c%0d: freeze %b read %b write %b exp 0 0 0", c, freeze, bus_read, bus_write);
      end
      tests_run++;
      if (mem_err !== (c == 1)) begin
        tests_failed++; $display("FAIL ill_err c%0d: got %b exp %b", c, mem_err, c == 1);
      end
      next_cycle();
      if (c == 0) begin read_mem = 0; write_mem = 0; end
    end
  endtask

  task automatic test_misalign();
    read_mem = 1; load_byte = 0; addr = 32'h101; bus_rdata = 32'h11223344; bus_busy = 0;
`ifdef MEM_MISALIGN_CHECK_EN
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (freeze !== (c == 0) || mem_err !== (c == 1)) begin
        tests_failed++; $display("FAIL mis_ctrl c%0d: freeze %b err %b", c, freeze, mem_err);
      end
      tests_run++;
      if (bus_read !== 1'b0 || load_valid !== 1'b0) begin
        tests_failed++; $display("FAIL mis_bus c%0d: read %b valid %b exp 0 0", c, bus_read, load_valid);
      end
      next_cycle();
      if (c == 0) read_mem = 0;
    end
`else
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus_read !== (c == 1) || load_valid !== (c == 3) || mem_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL mis_ctrl c%0d: read %b valid %b err %b", c, bus_read, load_valid, mem_err);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_addr !== 32'h100 || bus_sel !== 4'hF) begin
          tests_failed++; $display("FAIL mis_bus: addr %h sel %h exp 00000100 f", bus_addr, bus_sel);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (load_data !== 32'h11223344) begin
          tests_failed++; $display("FAIL mis_data: got %h exp 11223344", load_data);
        end
      end
      next_cycle();
      if (c == 0) read_mem = 0;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lb_busy();
    test_timeout();
    test_reset_mid();
    test_illegal();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
